// File: rtl/vga_timing_gen_if.sv
// Pixel-tick inputs and VGA timing outputs of vga_timing_gen.
// The frame_cnt signal exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic       enable;
  logic       flag_pixel;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       line_end;
  logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  modport master (
    input  enable, flag_pixel,
    output hsync, vsync, video_on, pix_x, pix_y, line_end, frame_start, frame_cnt
  );
  modport slave (
    output enable, flag_pixel,
    input  hsync, vsync, video_on, pix_x, pix_y, line_end, frame_start, frame_cnt
  );
`else
  modport master (
    input  enable, flag_pixel,
    output hsync, vsync, video_on, pix_x, pix_y, line_end, frame_start
  );
  modport slave (
    output enable, flag_pixel,
    input  hsync, vsync, video_on, pix_x, pix_y, line_end, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator advanced by rising edges of flag_pixel.
// Optional macro VGA_FRAME_CNT_EN adds an 8-bit wrapping frame counter output.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               n_rst,
  vga_timing_gen_if.master   vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic in_win(input logic [9:0] val, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  logic       flag_d;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       tick;
  logic       adv;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       video_nxt;

  // Stage 0: tick detection and next-state counters
  always_comb begin
    tick      = vif.flag_pixel & ~flag_d;
    adv       = tick & vif.enable;
    h_wrap    = adv && (h_cnt == H_LAST);
    v_wrap    = h_wrap && (v_cnt == V_LAST);
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    if (adv) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
    video_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // Stage 1: counters and outputs registered together, decoded from next state
  always_ff @(posedge clk) begin
    if (n_rst) begin
      flag_d          <= 1'b0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      vif.hsync       <= ~SYNC_POL;
      vif.vsync       <= ~SYNC_POL;
      vif.video_on    <= 1'b1;
      vif.pix_x       <= '0;
      vif.pix_y       <= '0;
      vif.line_end    <= 1'b0;
      vif.frame_start <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      vif.frame_cnt   <= '0;
`endif
    end else begin
      // flag_d tracks even while disabled so re-enable cannot see a stale edge
      flag_d          <= vif.flag_pixel;
      h_cnt           <= h_nxt;
      v_cnt           <= v_nxt;
      vif.hsync       <= in_win(h_nxt, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vif.vsync       <= in_win(v_nxt, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
      vif.video_on    <= video_nxt;
      vif.pix_x       <= video_nxt ? h_nxt : '0;
      vif.pix_y       <= video_nxt ? v_nxt : '0;
      vif.line_end    <= h_wrap;
      vif.frame_start <= v_wrap;
`ifdef VGA_FRAME_CNT_EN
      vif.frame_cnt   <= vif.frame_cnt + 8'(v_wrap);
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized and directed bench for vga_timing_gen: a full-size 640x480 instance
// and a reduced-geometry, active-high-sync instance share the same stimulus.
module tb_vga_timing_gen;

  localparam int SH_A = 20, SH_F = 4, SH_S = 6, SH_B = 5;
  localparam int SV_A = 10, SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int D_FRAME = 800 * 525;
  localparam int S_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

  logic clk;
  logic rst;
  vga_timing_gen_if vif_d ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen dut_d (.clk(clk), .n_rst(rst), .vif(vif_d));

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b1)
  ) dut_s (.clk(clk), .n_rst(rst), .vif(vif_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ticks    = 0;   // pixel ticks applied since the last reset
  logic prev_fp  = 1'b0;
  logic adv      = 1'b0;
  int   fc_d     = 0;
  int   fc_s     = 0;
  logic fp_drv   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected output vector {hsync,vsync,video_on,pix_x,pix_y,line_end,frame_start}
  // derived from the absolute tick count by division/modulo on the frame geometry.
  function automatic logic [24:0] exp_vec(input int t, input logic a,
      input int ha, input int hfp, input int hs, input int hbp,
      input int va, input int vfp, input int vs, input int vbp, input logic pol);
    int ht, vt, p, h, v;
    logic von, hsy, vsy;
    logic [9:0] px, py;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    p   = t % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    von = (h < ha) && (v < va);
    hsy = (h >= ha + hfp && h < ha + hfp + hs) ? pol : ~pol;
    vsy = (v >= va + vfp && v < va + vfp + vs) ? pol : ~pol;
    px  = von ? 10'(h) : 10'd0;
    py  = von ? 10'(v) : 10'd0;
    return {hsy, vsy, von, px, py, a && (h == 0), a && (p == 0)};
  endfunction

  function automatic logic [24:0] obs_d();
    return {vif_d.hsync, vif_d.vsync, vif_d.video_on, vif_d.pix_x, vif_d.pix_y,
            vif_d.line_end, vif_d.frame_start};
  endfunction

  function automatic logic [24:0] obs_s();
    return {vif_s.hsync, vif_s.vsync, vif_s.video_on, vif_s.pix_x, vif_s.pix_y,
            vif_s.line_end, vif_s.frame_start};
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic cyc(input logic r, input logic e, input logic f);
    rst = r;
    vif_d.enable = e;  vif_d.flag_pixel = f;
    vif_s.enable = e;  vif_s.flag_pixel = f;
    @(posedge clk);
    if (r) begin
      ticks = 0; prev_fp = 1'b0; adv = 1'b0; fc_d = 0; fc_s = 0;
    end else begin
      adv     = f & ~prev_fp & e;
      prev_fp = f;
      if (adv) begin
        ticks++;
        if (ticks % D_FRAME == 0) fc_d++;
        if (ticks % S_FRAME == 0) fc_s++;
      end
    end
    #1;
    check("full_geom", 32'(obs_d()),
          32'(exp_vec(ticks, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
    check("small_geom", 32'(obs_s()),
          32'(exp_vec(ticks, adv, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1)));
`ifdef VGA_FRAME_CNT_EN
    check("frame_cnt_full", 32'(vif_d.frame_cnt), 32'(fc_d % 256));
    check("frame_cnt_small", 32'(vif_s.frame_cnt), 32'(fc_s % 256));
`endif
  endtask

  // Toggle flag_pixel every clk with enable high until the tick count reaches n.
  task automatic run_to(input int n);
    for (int i = 0; i < 8000; i++) begin
      if (ticks == n) return;
      fp_drv = ~fp_drv;
      cyc(1'b0, 1'b1, fp_drv);
    end
    check("run_to_timeout", 32'(ticks), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    vif_d.enable = 1'b0; vif_d.flag_pixel = 1'b0;
    vif_s.enable = 1'b0; vif_s.flag_pixel = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("rst_hsync", 32'(vif_d.hsync), 32'd1);
    check("rst_vsync", 32'(vif_d.vsync), 32'd1);
    check("rst_video_on", 32'(vif_d.video_on), 32'd1);
    check("rst_pix_x", 32'(vif_d.pix_x), 32'd0);
    check("rst_pix_y", 32'(vif_d.pix_y), 32'd0);
    check("rst_line_end", 32'(vif_d.line_end), 32'd0);
    check("rst_frame_start", 32'(vif_d.frame_start), 32'd0);
    fp_drv = 1'b0;

    // Horizontal timing on the full-size instance
    run_to(639);
    check("h639_pix_x", 32'(vif_d.pix_x), 32'd639);
    check("h639_video_on", 32'(vif_d.video_on), 32'd1);
    run_to(640);
    check("h640_video_on", 32'(vif_d.video_on), 32'd0);
    check("h640_pix_x", 32'(vif_d.pix_x), 32'd0);
    run_to(655);
    check("h655_hsync", 32'(vif_d.hsync), 32'd1);
    run_to(656);
    check("h656_hsync", 32'(vif_d.hsync), 32'd0);
    run_to(751);
    check("h751_hsync", 32'(vif_d.hsync), 32'd0);
    run_to(752);
    check("h752_hsync", 32'(vif_d.hsync), 32'd1);
    run_to(800);
    check("h800_line_end", 32'(vif_d.line_end), 32'd1);
    check("h800_frame_start", 32'(vif_d.frame_start), 32'd0);
    check("h800_pix_x", 32'(vif_d.pix_x), 32'd0);
    check("h800_pix_y", 32'(vif_d.pix_y), 32'd1);

    // Enable hold at h=100 while flag_pixel keeps toggling
    run_to(900);
    for (int i = 0; i < 37; i++) begin
      fp_drv = ~fp_drv;
      cyc(1'b0, 1'b0, fp_drv);
    end
    check("hold_pix_x", 32'(vif_d.pix_x), 32'd100);
    run_to(901);
    check("resume_pix_x", 32'(vif_d.pix_x), 32'd101);

    // Level immunity: flag_pixel held high gives exactly one tick
    if (fp_drv) begin
      fp_drv = 1'b0;
      cyc(1'b0, 1'b1, 1'b0);
    end
    fp_drv = 1'b1;
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 1'b1);
    check("level_pix_x", 32'(vif_d.pix_x), 32'd102);

    // Randomized flag/enable patterns with occasional resets
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 1) == 0) fp_drv = ~fp_drv;
      cyc(($urandom_range(0, 2499) == 0), ($urandom_range(0, 9) != 0), fp_drv);
    end

    // Vertical timing and frame wrap on the small instance
    fp_drv = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    run_to(419);
    check("s_v11_vsync", 32'(vif_s.vsync), 32'd0);
    run_to(420);
    check("s_v12_vsync", 32'(vif_s.vsync), 32'd1);
    run_to(489);
    check("s_v13_vsync", 32'(vif_s.vsync), 32'd1);
    run_to(490);
    check("s_v14_vsync", 32'(vif_s.vsync), 32'd0);
    run_to(S_FRAME);
    check("s_frame_start", 32'(vif_s.frame_start), 32'd1);
    check("s_wrap_line_end", 32'(vif_s.line_end), 32'd1);
    check("s_wrap_pix", 32'({vif_s.pix_x, vif_s.pix_y}), 32'd0);
`ifdef VGA_FRAME_CNT_EN
    check("s_frame_cnt_one", 32'(vif_s.frame_cnt), 32'd1);
`endif
    cyc(1'b0, 1'b1, fp_drv);
    check("s_frame_start_drop", 32'(vif_s.frame_start), 32'd0);

    // Mid-frame reset with hsync asserted on both instances
    cyc(1'b1, 1'b0, 1'b0);
    fp_drv = 1'b0;
    run_to(2300);
    check("mid_hsync_asserted", 32'(vif_d.hsync), 32'd0);
    fp_drv = ~fp_drv;
    cyc(1'b1, 1'b1, fp_drv);
    check("mid_rst_hsync", 32'(vif_d.hsync), 32'd1);
    check("mid_rst_pix", 32'({vif_d.pix_x, vif_d.pix_y}), 32'd0);
    check("mid_rst_pulses", 32'({vif_d.line_end, vif_d.frame_start}), 32'd0);
    check("mid_rst_small_hsync", 32'(vif_s.hsync), 32'd0);
    for (int i = 0; i < 20; i++) begin
      fp_drv = ~fp_drv;
      cyc(1'b0, 1'b1, fp_drv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the pixel-rate toggle `flag_pixel` from the pixel clock divider.
- Each rising edge of `flag_pixel` is one pixel tick.
- On each tick the block advances horizontal and vertical counters and produces registered VGA sync, blanking and pixel-coordinate outputs for the frame-buffer fetch and DAC stages.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous, active-high reset (1 = reset on the clk rising edge; port name kept from the codebase)
enable  in  1  1 = advance on pixel ticks; 0 = freeze counters
flag_pixel  in  1  pixel toggle from the divider; its rising edge is the tick
hsync  out  1  horizontal sync at SYNC_POL level during the sync window
vsync  out  1  vertical sync at SYNC_POL level during the sync window
video_on  out  1  1 while h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
pix_x  out  10  h_cnt when video_on, else 0
pix_y  out  10  v_cnt when video_on, else 0
line_end  out  1  1-clk pulse on the tick that wraps h_cnt to 0
frame_start  out  1  1-clk pulse on the tick that wraps both counters to (0,0)

Behaviour:
- Internal state:
  - flag_d: 1-bit register.
  - h_cnt, v_cnt: 10-bit counters.
  - H_TOTAL = sum of the H params (800); V_TOTAL = sum of the V params (525). Both must be ≤ 1024.
- Tick detection:
  - tick = flag_pixel & ~flag_d.
  - flag_d <= flag_pixel every clk, regardless of enable, so no spurious tick fires on re-enable.
  - flag_pixel held high for any number of clks gives exactly one tick.
- Counting, on a clk where tick & enable:
  - h_cnt == H_TOTAL-1: h_cnt <= 0.
    - v_cnt == V_TOTAL-1: v_cnt <= 0.
    - Otherwise: v_cnt <= v_cnt + 1.
  - Otherwise: h_cnt <= h_cnt + 1.
  - On any other clk, the counters hold.
- Output timing:
  - All outputs are registered and decoded from the next-state counter values.
  - They change on the same clk edge as the counters, so there is zero lag relative to h_cnt/v_cnt.
- hsync asserted iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
- vsync asserted iff v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491].
- "Asserted" means driven to SYNC_POL; otherwise the output is ~SYNC_POL.
- line_end / frame_start:
  - High for exactly the one clk following the wrapping edge.
  - 0 on all other clks, including while enable = 0.
  - frame_start implies line_end in the same clk.
- Reset (n_rst = 1 at a clk edge):
  - flag_d, h_cnt, v_cnt = 0.
  - hsync = vsync = ~SYNC_POL; video_on = 1; pix_x = pix_y = 0; line_end = frame_start = 0.
  - Reset overrides tick and enable in the same cycle.
  - Mid-frame reset restarts at (0,0) with no pulses.
- Simultaneous tick with enable falling: enable is sampled on the same edge; if enable = 0 the tick is lost (not queued).

Optional Feature:
VGA_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt [7:0], reset 0.
  - Increments, wrapping 255→0, on the same edge that raises frame_start.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert n_rst 2 clks with flag_pixel = 0 → hsync = vsync = 1, video_on = 1, pix_x = pix_y = 0, line_end = frame_start = 0.
- Horizontal timing: enable = 1, flag_pixel toggling every 5 clks (10-clk tick period), count ticks from reset →
  - pix_x = 639 after tick 639, then video_on = 0 after tick 640.
  - hsync low after tick 656 through tick 751, high after tick 752.
  - line_end pulse after tick 800 with pix_x = 0, pix_y = 1.
- Vertical timing: run 525 lines →
  - vsync low for lines 490–491 only.
  - frame_start single pulse after tick 420000, counters at (0,0).
  - (VGA_FRAME_CNT_EN) frame_cnt = 1.
- Enable hold: drop enable for 37 clks at h_cnt = 100 while flag_pixel keeps toggling → h_cnt stays 100; resumes at 101 on the first tick after re-enable.
- Level immunity: hold flag_pixel = 1 for 50 clks → exactly one increment.
- Mid-frame reset: pulse n_rst 1 clk at (h = 700, v = 300), hsync asserted → next clk h = v = 0, hsync deasserted, no line_end/frame_start pulse.
